// File: rtl/uart_prog_loader_if.sv
// Loader-side bundle: serial pins, sequencer read port and status strobes.
// The loader takes the slave modport; the sequencer/host side takes master.
interface uart_prog_loader_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int AW          = 8
);
  logic                   uart_rx;
  logic                   uart_tx;
  logic [AW-1:0]          rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   cpu_hold;
  logic                   load_done;
  logic                   load_err;

  modport slave  (input  uart_rx, rd_addr,
                  output uart_tx, rd_data, cpu_hold, load_done, load_err);
  modport master (output uart_rx, rd_addr,
                  input  uart_tx, rd_data, cpu_hold, load_done, load_err);
endinterface

// File: rtl/uart_prog_loader.sv
// Framed UART boot-loader for the VPU instruction store (8N1 UART, ACK/NAK replies).
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CSUM_EN.
module uart_prog_loader #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 256,
  parameter int CLK_PER_BIT = 50,
  parameter int LITTLE_END  = 0,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic             clk,
  input  logic             rst,
  uart_prog_loader_if.slave bus
);
  localparam int BPW = INSTR_WIDTH / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [15:0] CPB_M1   = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] CPB_HALF = 16'(CLK_PER_BIT / 2);
  localparam logic [7:0] SYNC = 8'hA5, CMD_WR = 8'h01, CMD_PING = 8'h02;
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_AHI, S_ALO, S_CHI, S_CLO, S_DATA,
`ifdef UART_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_RESP
  } state_t;

`ifdef UART_LOADER_CSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_RESP;
`endif

  // Receiver: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  logic [1:0]  rx_sync_q;
  logic        rx_busy_q, rx_done_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
      rx_busy_q <= 1'b0;
      rx_done_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], bus.uart_rx};
      rx_done_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_sync_q[1]) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= CPB_HALF;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != 16'd0) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= CPB_M1;
        if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_done_q <= rx_sync_q[1];
        end else if (rx_bit_q == 4'd0 && rx_sync_q[1]) begin
          rx_busy_q <= 1'b0;
        end else begin
          if (rx_bit_q != 4'd0) rx_sh_q <= {rx_sync_q[1], rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  // Transmitter: idle shift register is all ones, so bit 0 is the line level.
  logic [9:0]  tx_sh_q;
  logic [3:0]  tx_bits_q;
  logic [15:0] tx_cnt_q;
  logic        tx_busy, tx_en;
  logic [7:0]  tx_byte;

  assign tx_busy = (tx_bits_q != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_q   <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_en) begin
      tx_sh_q   <= {1'b1, tx_byte, 1'b0};
      tx_bits_q <= 4'd10;
      tx_cnt_q  <= CPB_M1;
    end else if (tx_busy) begin
      if (tx_cnt_q == 16'd0) begin
        tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
        tx_bits_q <= tx_bits_q - 4'd1;
        tx_cnt_q  <= CPB_M1;
      end else begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end
    end
  end

  state_t                 state_q, state_d;
  logic [7:0]             hdr_q, hdr_d, csum_q, csum_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW:0]            words_q, words_d;
  logic [3:0]             bidx_q, bidx_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic                   nak_q, nak_d, iswr_q, iswr_d, wr_en_q, wr_en_d;
  logic [31:0]            tmo_q, tmo_d;
  logic                   hold, done_p, err_p;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;  hdr_d  = hdr_q;  csum_d = csum_q; ptr_d   = ptr_q;
    words_d = words_q;  bidx_d = bidx_q; word_d = word_q; nak_d   = nak_q;
    iswr_d  = iswr_q;   wr_en_d = 1'b0;  tmo_d  = '0;     tx_en   = 1'b0;
    done_p  = 1'b0;     err_p   = 1'b0;
    tx_byte = nak_q ? NAK : ACK;
    hold    = (state_q != S_IDLE) && (state_q != S_CMD);
    if (wr_en_q) ptr_d = ptr_q + 1'b1;
    // A byte arriving in the expiry cycle wins and restarts the idle count.
    if (state_q != S_IDLE && state_q != S_RESP) begin
      tmo_d = rx_done_q ? 32'd0 : tmo_q + 32'd1;
      if (TIMEOUT_CYC != 0 && !rx_done_q && tmo_q == 32'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        err_p   = 1'b1;
      end
    end
    case (state_q)
      S_IDLE: if (rx_done_q && rx_sh_q == SYNC) state_d = S_CMD;
      S_CMD: if (rx_done_q) begin
        hold   = 1'b1;
        csum_d = rx_sh_q;
        nak_d  = 1'b0;
        iswr_d = (rx_sh_q == CMD_WR);
        if (rx_sh_q == CMD_WR)        state_d = S_AHI;
        else if (rx_sh_q == CMD_PING) state_d = S_END;
        else begin
          nak_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_AHI, S_CHI: if (rx_done_q) begin
        hdr_d   = rx_sh_q;
        csum_d  = csum_q ^ rx_sh_q;
        state_d = (state_q == S_AHI) ? S_ALO : S_CLO;
      end
      S_ALO: if (rx_done_q) begin
        ptr_d   = AW'({hdr_q, rx_sh_q});
        csum_d  = csum_q ^ rx_sh_q;
        state_d = S_CHI;
      end
      S_CLO: if (rx_done_q) begin
        words_d = (AW+1)'({hdr_q, rx_sh_q}) + 1'b1;
        bidx_d  = '0;
        csum_d  = csum_q ^ rx_sh_q;
        state_d = S_DATA;
      end
      S_DATA: if (rx_done_q) begin
        csum_d = csum_q ^ rx_sh_q;
        if (LITTLE_END != 0)
          word_d = (word_q >> 8) | (INSTR_WIDTH'(rx_sh_q) << (INSTR_WIDTH - 8));
        else
          word_d = (word_q << 8) | INSTR_WIDTH'(rx_sh_q);
        if (bidx_q == 4'(BPW - 1)) begin
          bidx_d  = '0;
          wr_en_d = 1'b1;
          words_d = words_q - 1'b1;
          if (words_q == (AW+1)'(1)) state_d = S_END;
        end else begin
          bidx_d = bidx_q + 4'd1;
        end
      end
`ifdef UART_LOADER_CSUM_EN
      S_CSUM: if (rx_done_q) begin
        nak_d   = (rx_sh_q != csum_q);
        state_d = S_RESP;
      end
`endif
      S_RESP: if (!tx_busy) begin
        tx_en   = 1'b1;
        hold    = 1'b0;
        done_p  = !nak_q && iswr_q;
        err_p   = nak_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      nak_q   <= 1'b0;
      iswr_q  <= 1'b0;
      wr_en_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      nak_q   <= nak_d;
      iswr_q  <= iswr_d;
      wr_en_q <= wr_en_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    hdr_q  <= hdr_d;
    csum_q <= csum_d;
    word_q <= word_d;
    if (wr_en_q) mem_q[ptr_q] <= word_q;
  end

  assign bus.uart_tx   = tx_sh_q[0];
  assign bus.rd_data   = mem_q[bus.rd_addr];
  assign bus.cpu_hold  = hold;
  assign bus.load_done = done_p;
  assign bus.load_err  = err_p;
endmodule
